// File: rtl/lsu_controller.sv
// lsu_controller: load/store unit sequencer for the data-memory port.
//   Takes decoded load/store controls from execute, checks alignment, drives a
//   request/grant data bus with byte enables and lane-replicated store data,
//   aligns and sign/zero-extends load data, stalls the pipeline while an
//   access is in flight, and flags hung loads with a cycle-count timeout.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   data_req_i, data_wr_i      request, 1 = store / 0 = load
//   data_byte_i, zero_extnd_i  size (00 B, 01 H, 1x W), zero-extend loads
//   addr_i, wr_data_i          byte address, store data
//   lsu_stall_o                pipeline stall
//   mem_req_o/mem_gnt_i        bus request held until grant
//   mem_addr_o, mem_wr_o       word-aligned address, write strobe
//   mem_be_o, mem_wdata_o      byte enables, replicated write data
//   mem_rvalid_i, mem_rdata_i  read response
//   rd_data_o                  aligned, extended load result
//   done_o, misalign_o, bus_err_o  completion pulse and its status flags
module lsu_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req_i,
  input  logic        data_wr_i,
  input  logic [1:0]  data_byte_i,
  input  logic        zero_extnd_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wr_data_i,
  output logic        lsu_stall_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_wr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] rd_data_o,
  output logic        done_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_next;
  logic [15:0] cnt;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        zext_q;
  logic        misaligned;
  logic        timeout_hit;
  logic        load_ok;

  function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   be_for = 4'b0001 << off;
      2'b01:   be_for = 4'b0011 << {off[1], 1'b0};
      default: be_for = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_for(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   wdata_for = {4{d[7:0]}};
      2'b01:   wdata_for = {2{d[15:0]}};
      default: wdata_for = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] size, input logic zext,
                                               input logic [1:0] off, input logic [31:0] d);
    logic [31:0] s;
    s = d >> {off, 3'b000};
    case (size)
      2'b00:   load_extract = zext ? {24'h0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
      2'b01:   load_extract = zext ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: load_extract = s;
    endcase
  endfunction

  assign misaligned  = ((data_byte_i == 2'b01) & addr_i[0]) |
                       (data_byte_i[1] & (addr_i[1:0] != 2'b00));
  assign timeout_hit = (cnt == 16'(TIMEOUT_CYCLES - 1));
  // A load completes successfully when data arrives with the grant or later in WAIT.
  assign load_ok     = !mem_wr_o & mem_rvalid_i &
                       (((state == REQ) & mem_gnt_i) | (state == WAIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    lsu_stall_o = 1'b0;
    done_o      = 1'b0;
    case (state)
      IDLE: begin
        lsu_stall_o = data_req_i;
        if (data_req_i) state_next = misaligned ? DONE : REQ;
      end
      REQ: begin
        lsu_stall_o = 1'b1;
        if (mem_gnt_i) state_next = (mem_wr_o | mem_rvalid_i) ? DONE : WAIT;
      end
      WAIT: begin
        lsu_stall_o = 1'b1;
        if (mem_rvalid_i | timeout_hit) state_next = DONE;
      end
      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req_o   <= 1'b0;
      mem_addr_o  <= '0;
      mem_wr_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
      size_q      <= '0;
      off_q       <= '0;
      zext_q      <= 1'b0;
      cnt         <= '0;
      rd_data_o   <= '0;
      misalign_o  <= 1'b0;
      bus_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          misalign_o <= 1'b0;
          bus_err_o  <= 1'b0;
          if (data_req_i) begin
            if (misaligned) begin
              misalign_o <= 1'b1;
            end else begin
              mem_req_o   <= 1'b1;
              mem_addr_o  <= {addr_i[31:2], 2'b00};
              mem_wr_o    <= data_wr_i;
              mem_be_o    <= be_for(data_byte_i, addr_i[1:0]);
              mem_wdata_o <= wdata_for(data_byte_i, wr_data_i);
              size_q      <= data_byte_i;
              off_q       <= addr_i[1:0];
              zext_q      <= zero_extnd_i;
            end
          end
        end
        REQ: begin
          cnt <= '0;
          if (mem_gnt_i) mem_req_o <= 1'b0;
        end
        WAIT: begin
          cnt <= cnt + 16'd1;
          // Data arriving in the expiry cycle wins over the timeout.
          if (!mem_rvalid_i && timeout_hit) bus_err_o <= 1'b1;
        end
        DONE: begin
          misalign_o <= 1'b0;
          bus_err_o  <= 1'b0;
        end
        default: ;
      endcase
      if (load_ok) rd_data_o <= load_extract(size_q, zext_q, off_q, mem_rdata_i);
    end
  end

endmodule

// File: tb/tb_lsu_controller.sv
// tb_lsu_controller: directed table-driven bench for lsu_controller with a
// short timeout, plus hand sequences for spurious bus inputs and reset
// during an in-flight access.
module tb_lsu_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_req_i, data_wr_i, zero_extnd_i;
  logic [1:0]  data_byte_i;
  logic [31:0] addr_i, wr_data_i;
  logic        lsu_stall_o, mem_req_o, mem_gnt_i, mem_wr_o, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i, rd_data_o;
  logic [3:0]  mem_be_o;
  logic        done_o, misalign_o, bus_err_o;

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] last_rd = '0;

  always #5 clk = ~clk;

  lsu_controller #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .data_req_i(data_req_i), .data_wr_i(data_wr_i), .data_byte_i(data_byte_i),
    .zero_extnd_i(zero_extnd_i), .addr_i(addr_i), .wr_data_i(wr_data_i),
    .lsu_stall_o(lsu_stall_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_addr_o(mem_addr_o), .mem_wr_o(mem_wr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .rd_data_o(rd_data_o), .done_o(done_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        zext;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gd;       // cycles in REQ before grant
    int          rvd;      // cycles after grant until rvalid (0 = with grant, 255 = never)
    logic [31:0] rdata;
    logic        ld;       // load that updates rd_data_o
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rd;
    logic        exp_mis;
    logic        exp_berr;
    int          exp_req;
    int          exp_stall;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_access(input vec_t v);
    int  req_cycles = 0;
    int  stall_cycles = 0;
    int  waited = 0;
    int  gcnt = 0;
    bit  granted = 0;
    bit  done_seen = 0;
    bit  mem_checked = 0;
    chk("done_low_before", {31'b0, done_o}, 32'd0);
    data_req_i = 1'b1; data_wr_i = v.wr; data_byte_i = v.size;
    zero_extnd_i = v.zext; addr_i = v.addr; wr_data_i = v.wdata;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h5A5A_5A5A;
      if (done_o) begin
        done_seen  = 1;
        data_req_i = 1'b0;
        chk("misalign", {31'b0, misalign_o}, {31'b0, v.exp_mis});
        chk("bus_err", {31'b0, bus_err_o}, {31'b0, v.exp_berr});
        chk("rd_data", rd_data_o, v.ld ? v.exp_rd : last_rd);
      end else if (mem_req_o) begin
        req_cycles++;
        if (!mem_checked) begin
          mem_checked = 1;
          chk("mem_addr", mem_addr_o, {v.addr[31:2], 2'b00});
          chk("mem_be", {28'b0, mem_be_o}, {28'b0, v.exp_be});
          chk("mem_wdata", mem_wdata_o, v.exp_wdata);
          chk("mem_wr", {31'b0, mem_wr_o}, {31'b0, v.wr});
        end
        if (gcnt == v.gd) begin
          mem_gnt_i = 1'b1;
          granted = 1;
          if (!v.wr && v.rvd == 0) begin mem_rvalid_i = 1'b1; mem_rdata_i = v.rdata; end
        end
        gcnt++;
      end else if (granted) begin
        waited++;
        if (waited == v.rvd) begin mem_rvalid_i = 1'b1; mem_rdata_i = v.rdata; end
      end
      #1;
      if (lsu_stall_o) stall_cycles++;
      step();
    end
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    chk("done_seen", {31'b0, done_seen}, 32'd1);
    chk("req_cycles", req_cycles, v.exp_req);
    chk("stall_cycles", stall_cycles, v.exp_stall);
    if (v.ld) last_rd = v.exp_rd;
  endtask

  vec_t vecs[15];

  initial begin
    //        wr    sz     zx    addr          wdata         gd rvd  rdata         ld    be       exp_wdata     exp_rd        mis   berr req stall
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'hDEAD_BEEF, 0, 1,   32'h80FF_FFFF, 1'b1, 4'b1000, 32'hEFEF_EFEF, 32'hFFFF_FF80, 1'b0, 1'b0, 1, 3};
    vecs[1]  = '{1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h1234_5678, 0, 0,   32'h9ABC_1234, 1'b1, 4'b1100, 32'h5678_5678, 32'h0000_9ABC, 1'b0, 1'b0, 1, 2};
    vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h0000_3001, 32'h1122_3344, 4, 0,   32'h0,         1'b0, 4'b0010, 32'h4444_4444, 32'h0,         1'b0, 1'b0, 5, 6};
    vecs[3]  = '{1'b0, 2'b10, 1'b0, 32'h0000_4002, 32'h0,         0, 0,   32'h0,         1'b0, 4'b0000, 32'h0,         32'h0,         1'b1, 1'b0, 0, 1};
    vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0006, 32'h0,         1, 2,   32'h8001_0000, 1'b1, 4'b1100, 32'h0,         32'hFFFF_8001, 1'b0, 1'b0, 2, 5};
    vecs[5]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0001, 32'h0,         0, 4,   32'h0000_A500, 1'b1, 4'b0010, 32'h0,         32'h0000_00A5, 1'b0, 1'b0, 1, 6};
    vecs[6]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hCAFE_BABE, 0, 0,   32'h0,         1'b0, 4'b1111, 32'hCAFE_BABE, 32'h0,         1'b0, 1'b0, 1, 2};
    vecs[7]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'h0,         0, 0,   32'h0,         1'b0, 4'b0000, 32'h0,         32'h0,         1'b1, 1'b0, 0, 1};
    vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h0000_000A, 32'h0000_BEEF, 2, 0,   32'h0,         1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0,         1'b0, 1'b0, 3, 4};
    vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         0, 1,   32'h1234_5678, 1'b1, 4'b1111, 32'h0,         32'h1234_5678, 1'b0, 1'b0, 1, 3};
    vecs[10] = '{1'b0, 2'b11, 1'b0, 32'h0000_0014, 32'h0,         0, 1,   32'hFFFF_0000, 1'b1, 4'b1111, 32'h0,         32'hFFFF_0000, 1'b0, 1'b0, 1, 3};
    vecs[11] = '{1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_00AB, 0, 0,   32'h0,         1'b0, 4'b1000, 32'hABAB_ABAB, 32'h0,         1'b0, 1'b0, 1, 2};
    vecs[12] = '{1'b0, 2'b00, 1'b0, 32'h0000_0000, 32'h0,         0, 1,   32'h0000_007F, 1'b1, 4'b0001, 32'h0,         32'h0000_007F, 1'b0, 1'b0, 1, 3};
    vecs[13] = '{1'b0, 2'b10, 1'b0, 32'h0000_0001, 32'h0,         0, 0,   32'h0,         1'b0, 4'b0000, 32'h0,         32'h0,         1'b1, 1'b0, 0, 1};
    vecs[14] = '{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         0, 255, 32'h0,         1'b0, 4'b1111, 32'h0,         32'h0,         1'b0, 1'b1, 1, 6};

    reset = 1'b1; data_req_i = 1'b0; data_wr_i = 1'b0; data_byte_i = 2'b00;
    zero_extnd_i = 1'b0; addr_i = '0; wr_data_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    step(); step();
    chk("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    chk("rst_rd_data", rd_data_o, 32'd0);
    chk("rst_stall", {31'b0, lsu_stall_o}, 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 15; i++) run_access(vecs[i]);

    // Late/spurious bus responses while IDLE are ignored.
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    step(); step();
    chk("late_rvalid_rd", rd_data_o, last_rd);
    chk("late_rvalid_done", {31'b0, done_o}, 32'd0);
    chk("late_rvalid_req", {31'b0, mem_req_o}, 32'd0);
    chk("late_rvalid_stall", {31'b0, lsu_stall_o}, 32'd0);
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    step();

    // Reset while in REQ drops the bus request without waiting for a clock.
    data_req_i = 1'b1; data_wr_i = 1'b1; data_byte_i = 2'b10; addr_i = 32'h0000_0050;
    wr_data_i = 32'h0BAD_F00D;
    step();
    chk("req_before_rst", {31'b0, mem_req_o}, 32'd1);
    data_req_i = 1'b0; reset = 1'b1;
    #1;
    chk("rst_req_async", {31'b0, mem_req_o}, 32'd0);
    chk("rst_req_addr", mem_addr_o, 32'd0);
    step();
    reset = 1'b0;
    step();

    // Reset while in WAIT aborts the load and clears every output.
    data_req_i = 1'b1; data_wr_i = 1'b0; data_byte_i = 2'b10; addr_i = 32'h0000_0030;
    step();
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    chk("wait_stall", {31'b0, lsu_stall_o}, 32'd1);
    chk("wait_req_low", {31'b0, mem_req_o}, 32'd0);
    data_req_i = 1'b0; reset = 1'b1;
    #1;
    chk("rst_wait_stall", {31'b0, lsu_stall_o}, 32'd0);
    chk("rst_wait_done", {31'b0, done_o}, 32'd0);
    chk("rst_wait_addr", mem_addr_o, 32'd0);
    chk("rst_wait_be", {28'b0, mem_be_o}, 32'd0);
    chk("rst_wait_rd", rd_data_o, 32'd0);
    last_rd = '0;
    step();
    reset = 1'b0;
    step();
    chk("post_rst_idle_done", {31'b0, done_o}, 32'd0);
    run_access('{1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 0, 1, 32'hA1B2_C3D4, 1'b1,
                 4'b1111, 32'h0, 32'hA1B2_C3D4, 1'b0, 1'b0, 1, 3});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
